regfile_wr_arbiter: RTL and testbench
=====================================

// Module: regfile_wr_arbiter
// PURPOSE
//  Shares the single register-file write port among NUM_REQ writeback sources
//  (index 0 = pipeline WB, 1 = load/store unit, 2 = mul/div/CSR).
//  - Arbitrates one request per cycle, round-robin or fixed priority.
//  - Registers the winner onto the regfile write port (rd_addr/rd_wr_data/rd_wr_en).
// PARAMETERS
//  NUM_REQ            3   number of write requesters (2..8)
//  REG_DATA_WIDTH     32  write-data width
//  REGFILE_ADDR_WIDTH 5   register address width
//  FIXED_PRIO         0   0 = round-robin; 1 = fixed priority, lowest index wins
// PORTS
//  clk_i          in   1                     clock, all state on rising edge
//  resetn_i       in   1                     reset, asynchronous, active-low
//  req_valid_i    in   NUM_REQ               per-requester write request
//  req_addr_i     in   NUM_REQ*ADDR_W        packed rd addresses, slot k at [k*ADDR_W +: ADDR_W]
//  req_data_i     in   NUM_REQ*DATA_W        packed write data, slot k at [k*DATA_W +: DATA_W]
//  req_ready_o    out  NUM_REQ               one-hot grant; request accepted when valid&ready
//  rd_addr_o      out  ADDR_W                to regfile rd_addr_i
//  rd_wr_data_o   out  DATA_W                to regfile rd_wr_data_i
//  rd_wr_en_o     out  1                     to regfile rd_wr_en_i
//  grant_idx_o    out  clog2(NUM_REQ)        index of the last accepted requester (debug/perf)
// BEHAVIOUR
//  Reset (async, resetn_i=0): takes effect immediately, no clock needed.
//   - rd_wr_en_o=0, rd_addr_o=0, rd_wr_data_o=0, grant_idx_o=0.
//   - RR pointer = NUM_REQ-1, so requester 0 has first priority.
//   - req_ready_o=0 while reset is asserted.
//  Arbitration (combinational, same cycle):
//   - At most one req_ready_o bit is set, and only for a requester with valid=1.
//   - No valid requests -> req_ready_o=0.
//   - The output stage is never stalled: exactly one request is accepted whenever any valid is 1.
//   - RR: search starts at ptr+1 mod NUM_REQ; the first valid requester wins.
//     On acceptance ptr <= winner. No acceptance -> ptr holds.
//   - FIXED_PRIO=1: lowest-index valid requester wins; ptr unused.
//  Handshake rules:
//   - A requester holds valid, addr and data stable until it sees ready.
//   - valid may drop only in the cycle after acceptance.
//   - ready may depend combinationally on valid; valid must not depend on ready.
//  Write stage (1-cycle latency):
//   - Accepted in cycle N -> during cycle N+1 rd_addr_o/rd_wr_data_o carry the
//     winner's values and rd_wr_en_o=1. The regfile commits at the end of N+1.
//   - Accepted addr == 0 -> the request is acknowledged normally, ptr advances,
//     and rd_wr_en_o=0 in N+1 (x0 is never written).
//   - No acceptance in N -> rd_wr_en_o=0 in N+1.
//     rd_addr_o/rd_wr_data_o keep their last values; consumers must ignore them.
//   - grant_idx_o updates only on acceptance.
//  Ordering and collisions:
//   - Two requesters targeting the same rd in one cycle are serialized; the later
//     write wins in the regfile.
//   - The arbiter does not merge or drop writes.
//  Starvation bound:
//   - RR: a continuously valid requester is accepted within NUM_REQ cycles.
//   - FIXED_PRIO: no bound; upstream must guarantee requester 0 is not permanently valid.
//  Reset mid-operation: a write staged for N+1 is discarded (rd_wr_en_o forced 0).
//   The requester that was accepted in N treats its write as done; restart handles
//   the discarded write.
// TESTING
//  1. Assert resetn_i=0 between clock edges -> rd_wr_en_o=0 and req_ready_o=0
//     at once; after release, all valid -> req0 granted first.
//  2. Only req1 valid, addr=5, data=32'hDEADBEEF -> req_ready_o=3'b010 the same
//     cycle; next cycle rd_wr_en_o=1, rd_addr_o=5, rd_wr_data_o=32'hDEADBEEF.
//  3. RR, all three valid for 6 cycles with distinct addr 1/2/3 -> grants 0,1,2,0,1,2;
//     rd_addr_o sequence 1,2,3,1,2,3, one cycle delayed.
//  4. req2 valid with addr=0 -> req_ready_o=3'b100 and ptr advances;
//     next cycle rd_wr_en_o=0.
//  5. FIXED_PRIO=1, req0 and req2 valid for 3 cycles, then req0 drops ->
//     req0 wins 3 cycles, req2 wins in cycle 4.
//  6. Idle cycle between writes -> rd_wr_en_o=0 in that cycle; random-traffic
//     scoreboard against a regfile model shows no lost or duplicated writes.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wr_arbiter
//
// Purpose:
//   Shares the single register-file write port among NUM_REQ writeback
//   sources (0 = pipeline WB, 1 = load/store unit, 2 = mul/div/CSR). One
//   request is granted per cycle, either round-robin or fixed priority
//   (lowest index wins). The winner is registered onto the write port, so a
//   request accepted in cycle N appears on rd_* during cycle N+1.
//
// Ports:
//   clk_i         in   clock, all state on rising edge
//   resetn_i      in   asynchronous active-low reset
//   req_valid_i   in   [NUM_REQ]            per-requester write request
//   req_addr_i    in   [NUM_REQ*ADDR_W]     packed rd addresses, slot k at [k*ADDR_W +: ADDR_W]
//   req_data_i    in   [NUM_REQ*DATA_W]     packed write data, slot k at [k*DATA_W +: DATA_W]
//   req_ready_o   out  [NUM_REQ]            one-hot grant, accepted when valid & ready
//   rd_addr_o     out  [ADDR_W]             regfile write address
//   rd_wr_data_o  out  [DATA_W]             regfile write data
//   rd_wr_en_o    out                       regfile write enable
//   grant_idx_o   out  [clog2(NUM_REQ)]     index of the last accepted requester
// -----------------------------------------------------------------------------
module regfile_wr_arbiter #(
    parameter int NUM_REQ            = 3,
    parameter int REG_DATA_WIDTH     = 32,
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter bit FIXED_PRIO         = 1'b0,
    localparam int IDX_W             = $clog2(NUM_REQ)
) (
    input  logic                                  clk_i,
    input  logic                                  resetn_i,
    input  logic [NUM_REQ-1:0]                    req_valid_i,
    input  logic [NUM_REQ*REGFILE_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*REG_DATA_WIDTH-1:0]     req_data_i,
    output logic [NUM_REQ-1:0]                    req_ready_o,
    output logic [REGFILE_ADDR_WIDTH-1:0]         rd_addr_o,
    output logic [REG_DATA_WIDTH-1:0]             rd_wr_data_o,
    output logic                                  rd_wr_en_o,
    output logic [IDX_W-1:0]                      grant_idx_o
);

    localparam int ADDR_W = REGFILE_ADDR_WIDTH;
    localparam int DATA_W = REG_DATA_WIDTH;
    // One extra bit so ptr+1+i (at most 2*NUM_REQ-1) never overflows
    // before the single conditional wrap.
    localparam int                CAND_W    = IDX_W + 1;
    localparam logic [CAND_W-1:0] NUM_REQ_C = CAND_W'(NUM_REQ);
    localparam logic [IDX_W-1:0]  PTR_RST   = IDX_W'(NUM_REQ - 1);

    logic [ADDR_W-1:0]  slot_addr [NUM_REQ];
    logic [DATA_W-1:0]  slot_data [NUM_REQ];
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic               accept;

    logic [IDX_W-1:0]   ptr_q,       ptr_d;
    logic               wr_en_q,     wr_en_d;
    logic [ADDR_W-1:0]  addr_q,      addr_d;
    logic [DATA_W-1:0]  data_q,      data_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;

    // Unpack the flat request buses and build the one-hot ready vector.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
            assign slot_addr[gi]   = req_addr_i[gi*ADDR_W +: ADDR_W];
            assign slot_data[gi]   = req_data_i[gi*DATA_W +: DATA_W];
            assign req_ready_o[gi] = accept && (win_idx == IDX_W'(gi));
        end
    endgenerate

    generate
        if (FIXED_PRIO) begin : g_fixed
            always_comb begin
                win_found = 1'b0;
                win_idx   = '0;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (!win_found && req_valid_i[i]) begin
                        win_found = 1'b1;
                        win_idx   = IDX_W'(i);
                    end
                end
            end
        end else begin : g_rr
            logic [CAND_W-1:0] cand;
            // Search order is ptr+1, ptr+2, ... (mod NUM_REQ); first valid wins.
            always_comb begin
                win_found = 1'b0;
                win_idx   = '0;
                cand      = '0;
                for (int i = 0; i < NUM_REQ; i++) begin
                    cand = {1'b0, ptr_q} + CAND_W'(i + 1);
                    if (cand >= NUM_REQ_C) begin
                        cand = cand - NUM_REQ_C;
                    end
                    if (!win_found && req_valid_i[cand[IDX_W-1:0]]) begin
                        win_found = 1'b1;
                        win_idx   = cand[IDX_W-1:0];
                    end
                end
            end
        end
    endgenerate

    // The output stage never stalls, so any valid request is accepted.
    // Grants are suppressed while reset is held so nobody sees a handshake
    // that the registers would then drop.
    assign accept = win_found && resetn_i;

    always_comb begin
        ptr_d       = ptr_q;
        wr_en_d     = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        grant_idx_d = grant_idx_q;
        if (accept) begin
            ptr_d       = win_idx;
            addr_d      = slot_addr[win_idx];
            data_d      = slot_data[win_idx];
            // x0 is hardwired: acknowledge the request but never write it.
            wr_en_d     = |slot_addr[win_idx];
            grant_idx_d = win_idx;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            ptr_q       <= PTR_RST;
            wr_en_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            grant_idx_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            wr_en_q     <= wr_en_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            grant_idx_q <= grant_idx_d;
        end
    end

    assign rd_addr_o    = addr_q;
    assign rd_wr_data_o = data_q;
    assign rd_wr_en_o   = wr_en_q;
    assign grant_idx_o  = grant_idx_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wr_arbiter
//
// Self-checking bench for regfile_wr_arbiter. A round-robin instance (u_rr) is
// followed every cycle by a reference model: at each falling edge the model
// predicts the grant, checks req_ready_o, and queues the expected write-port
// contents for the next cycle; the queued entry is popped and compared one
// cycle later. Directed scenario tasks add their own inline checks. A
// fixed-priority instance (u_fp) is exercised by a directed scenario.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_regfile_wr_arbiter;

    localparam int NR = 3;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic resetn;

    logic [NR-1:0]    valid;
    logic [NR*AW-1:0] addr_bus;
    logic [NR*DW-1:0] data_bus;
    logic [NR-1:0]    rr_ready;
    logic [AW-1:0]    rr_addr;
    logic [DW-1:0]    rr_data;
    logic             rr_en;
    logic [IW-1:0]    rr_gidx;

    logic [NR-1:0]    fp_valid;
    logic [NR*AW-1:0] fp_addr_bus;
    logic [NR*DW-1:0] fp_data_bus;
    logic [NR-1:0]    fp_ready;
    logic [AW-1:0]    fp_addr;
    logic [DW-1:0]    fp_data;
    logic             fp_en;
    logic [IW-1:0]    fp_gidx;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic          en;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [IW-1:0] idx;
    } wr_exp_t;

    wr_exp_t       sb_q[$];
    wr_exp_t       mon_e;
    int            mon_win;
    int            mon_c;
    logic [NR-1:0] mon_oh;
    int            m_ptr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [IW-1:0] m_gidx;

    logic [DW-1:0] exp_rf [32];
    logic [DW-1:0] dut_rf [32];
    int            exp_wr_cnt;
    int            dut_wr_cnt;

    regfile_wr_arbiter #(
        .NUM_REQ(NR), .REG_DATA_WIDTH(DW), .REGFILE_ADDR_WIDTH(AW), .FIXED_PRIO(1'b0)
    ) u_rr (
        .clk_i(clk), .resetn_i(resetn),
        .req_valid_i(valid), .req_addr_i(addr_bus), .req_data_i(data_bus),
        .req_ready_o(rr_ready), .rd_addr_o(rr_addr), .rd_wr_data_o(rr_data),
        .rd_wr_en_o(rr_en), .grant_idx_o(rr_gidx)
    );

    regfile_wr_arbiter #(
        .NUM_REQ(NR), .REG_DATA_WIDTH(DW), .REGFILE_ADDR_WIDTH(AW), .FIXED_PRIO(1'b1)
    ) u_fp (
        .clk_i(clk), .resetn_i(resetn),
        .req_valid_i(fp_valid), .req_addr_i(fp_addr_bus), .req_data_i(fp_data_bus),
        .req_ready_o(fp_ready), .rd_addr_o(fp_addr), .rd_wr_data_o(fp_data),
        .rd_wr_en_o(fp_en), .grant_idx_o(fp_gidx)
    );

    always #5 clk = ~clk;

    // Scoreboard / reference model for the round-robin instance.
    always @(negedge clk) begin
        if (!resetn) begin
            sb_q.delete();
            m_ptr  = NR - 1;
            m_addr = '0;
            m_data = '0;
            m_gidx = '0;
            sb_q.push_back(wr_exp_t'{en: 1'b0, addr: '0, data: '0, idx: '0});
        end else begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_underflow t=%0t: no expected write queued", $time);
            end else begin
                mon_e = sb_q.pop_front();
                if ({rr_en, rr_addr, rr_data, rr_gidx} !== mon_e) begin
                    n_fail++;
                    $display("FAIL sb_write t=%0t: got en=%b addr=%0d data=%h idx=%0d, expected en=%b addr=%0d data=%h idx=%0d",
                             $time, rr_en, rr_addr, rr_data, rr_gidx,
                             mon_e.en, mon_e.addr, mon_e.data, mon_e.idx);
                end
                if (mon_e.en) begin
                    exp_rf[mon_e.addr] = mon_e.data;
                    exp_wr_cnt++;
                end
            end
            if (rr_en === 1'b1) begin
                dut_rf[rr_addr] = rr_data;
                dut_wr_cnt++;
            end
            mon_win = -1;
            for (int i = 0; i < NR; i++) begin
                mon_c = (m_ptr + 1 + i) % NR;
                if (mon_win < 0 && valid[mon_c]) mon_win = mon_c;
            end
            mon_oh = (mon_win < 0) ? '0 : (NR'(1) << mon_win);
            n_checks++;
            if (rr_ready !== mon_oh) begin
                n_fail++;
                $display("FAIL sb_ready t=%0t: got %b expected %b", $time, rr_ready, mon_oh);
            end
            if (mon_win >= 0) begin
                m_ptr  = mon_win;
                m_addr = addr_bus[mon_win*AW +: AW];
                m_data = data_bus[mon_win*DW +: DW];
                m_gidx = IW'(mon_win);
                sb_q.push_back(wr_exp_t'{en: (m_addr != '0), addr: m_addr, data: m_data, idx: m_gidx});
            end else begin
                sb_q.push_back(wr_exp_t'{en: 1'b0, addr: m_addr, data: m_data, idx: m_gidx});
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        valid[k]              = v;
        addr_bus[k*AW +: AW]  = a;
        data_bus[k*DW +: DW]  = d;
    endtask

    task automatic set_fp(input int k, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        fp_valid[k]              = v;
        fp_addr_bus[k*AW +: AW]  = a;
        fp_data_bus[k*DW +: DW]  = d;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        next_cycle();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < NR; k++) set_req(k, 1'b1, AW'(k + 1), 32'hA000_0000 + DW'(k));
        @(negedge clk);
        n_checks++;
        if (rr_ready !== 3'b000) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 000", rr_ready);
        end
        n_checks++;
        if ({rr_en, rr_addr, rr_data, rr_gidx} !== 40'd0) begin
            n_fail++; $display("FAIL reset_outputs: got en=%b addr=%0d data=%h idx=%0d expected all 0",
                               rr_en, rr_addr, rr_data, rr_gidx);
        end
        next_cycle();
        resetn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (rr_ready !== 3'b001) begin
            n_fail++; $display("FAIL reset_first_grant: got %b expected 001", rr_ready);
        end
        next_cycle();
        set_req(0, 1'b1, 5'd1, 32'hA0A0_0001);
        #1;
        n_checks++;
        if (rr_en !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_wr_en: got %b expected 1", rr_en);
        end
        resetn = 1'b0;
        #1;
        n_checks++;
        if (rr_en !== 1'b0 || rr_ready !== 3'b000) begin
            n_fail++; $display("FAIL async_reset: got wr_en=%b ready=%b expected 0/000", rr_en, rr_ready);
        end
        next_cycle();
        next_cycle();
        resetn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (rr_ready !== 3'b001) begin
            n_fail++; $display("FAIL restart_first_grant: got %b expected 001", rr_ready);
        end
        next_cycle();
        valid = '0;
    endtask

    task automatic test_single();
        set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
        @(negedge clk);
        n_checks++;
        if (rr_ready !== 3'b010) begin
            n_fail++; $display("FAIL single_ready: got %b expected 010", rr_ready);
        end
        next_cycle();
        valid = '0;
        @(negedge clk);
        n_checks++;
        if (rr_en !== 1'b1 || rr_addr !== 5'd5 || rr_data !== 32'hDEADBEEF || rr_gidx !== 2'd1) begin
            n_fail++; $display("FAIL single_write: got en=%b addr=%0d data=%h idx=%0d expected 1/5/deadbeef/1",
                               rr_en, rr_addr, rr_data, rr_gidx);
        end
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] exp_oh;
        logic [AW-1:0] exp_addr;
        do_reset();
        for (int k = 0; k < NR; k++) set_req(k, 1'b1, AW'(k + 1), 32'h0000_0100 + DW'(k));
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c < 6) begin
                exp_oh = NR'(1) << (c % NR);
                n_checks++;
                if (rr_ready !== exp_oh) begin
                    n_fail++; $display("FAIL rr_grant[%0d]: got %b expected %b", c, rr_ready, exp_oh);
                end
            end
            if (c > 0) begin
                exp_addr = AW'(((c - 1) % NR) + 1);
                n_checks++;
                if (rr_en !== 1'b1 || rr_addr !== exp_addr) begin
                    n_fail++; $display("FAIL rr_wr_addr[%0d]: got en=%b addr=%0d expected 1/%0d",
                                       c, rr_en, rr_addr, exp_addr);
                end
            end
            next_cycle();
            if (c == 5) valid = '0;
        end
    endtask

    task automatic test_addr_zero();
        set_req(0, 1'b1, 5'd7, 32'h0000_0077);
        @(negedge clk);
        n_checks++;
        if (rr_ready !== 3'b001) begin
            n_fail++; $display("FAIL az_pre_grant: got %b expected 001", rr_ready);
        end
        next_cycle();
        valid = '0;
        set_req(2, 1'b1, 5'd0, 32'h0000_0022);
        @(negedge clk);
        n_checks++;
        if (rr_ready !== 3'b100) begin
            n_fail++; $display("FAIL az_grant: got %b expected 100", rr_ready);
        end
        next_cycle();
        set_req(2, 1'b1, 5'd9, 32'h0000_0099);
        set_req(0, 1'b1, 5'd10, 32'h0000_1010);
        @(negedge clk);
        n_checks++;
        if (rr_en !== 1'b0 || rr_gidx !== 2'd2) begin
            n_fail++; $display("FAIL az_no_write: got en=%b idx=%0d expected 0/2", rr_en, rr_gidx);
        end
        n_checks++;
        if (rr_ready !== 3'b001) begin
            n_fail++; $display("FAIL az_ptr_advanced: got %b expected 001", rr_ready);
        end
        next_cycle();
        valid[0] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rr_ready !== 3'b100) begin
            n_fail++; $display("FAIL az_followup: got %b expected 100", rr_ready);
        end
        next_cycle();
        valid = '0;
    endtask

    task automatic test_fixed_prio();
        logic [NR-1:0] exp_oh;
        set_fp(0, 1'b1, 5'd1, 32'h0000_00F0);
        set_fp(2, 1'b1, 5'd3, 32'h0000_00F2);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            exp_oh = (c < 3) ? 3'b001 : 3'b100;
            n_checks++;
            if (fp_ready !== exp_oh) begin
                n_fail++; $display("FAIL fp_grant[%0d]: got %b expected %b", c, fp_ready, exp_oh);
            end
            if (c > 0) begin
                n_checks++;
                if (fp_en !== 1'b1 || fp_addr !== 5'd1 || fp_data !== 32'h0000_00F0 + DW'(c - 1)) begin
                    n_fail++; $display("FAIL fp_write[%0d]: got en=%b addr=%0d data=%h expected 1/1/%h",
                                       c, fp_en, fp_addr, fp_data, 32'h0000_00F0 + DW'(c - 1));
                end
            end
            next_cycle();
            if (c < 2) fp_data_bus[DW-1:0] = 32'h0000_00F0 + DW'(c + 1);
            if (c == 2) fp_valid[0] = 1'b0;
        end
        fp_valid = '0;
        @(negedge clk);
        n_checks++;
        if (fp_en !== 1'b1 || fp_addr !== 5'd3 || fp_data !== 32'h0000_00F2 || fp_gidx !== 2'd2) begin
            n_fail++; $display("FAIL fp_last_write: got en=%b addr=%0d data=%h idx=%0d expected 1/3/f2/2",
                               fp_en, fp_addr, fp_data, fp_gidx);
        end
        next_cycle();
    endtask

    task automatic test_idle();
        set_req(0, 1'b1, 5'd4, 32'h0000_0044);
        @(negedge clk);
        next_cycle();
        valid = '0;
        @(negedge clk);
        n_checks++;
        if (rr_en !== 1'b1 || rr_addr !== 5'd4) begin
            n_fail++; $display("FAIL idle_w1: got en=%b addr=%0d expected 1/4", rr_en, rr_addr);
        end
        next_cycle();
        set_req(1, 1'b1, 5'd6, 32'h0000_0066);
        @(negedge clk);
        n_checks++;
        if (rr_en !== 1'b0 || rr_addr !== 5'd4 || rr_data !== 32'h0000_0044) begin
            n_fail++; $display("FAIL idle_gap: got en=%b addr=%0d data=%h expected 0/4/44",
                               rr_en, rr_addr, rr_data);
        end
        next_cycle();
        valid = '0;
        @(negedge clk);
        n_checks++;
        if (rr_en !== 1'b1 || rr_addr !== 5'd6 || rr_data !== 32'h0000_0066) begin
            n_fail++; $display("FAIL idle_w2: got en=%b addr=%0d data=%h expected 1/6/66",
                               rr_en, rr_addr, rr_data);
        end
        next_cycle();
    endtask

    task automatic test_random();
        logic [NR-1:0] acc;
        int            wait_cnt [NR];
        int            max_wait;
        int            rf_bad;
        for (int r = 0; r < 32; r++) begin
            exp_rf[r] = '0;
            dut_rf[r] = '0;
        end
        exp_wr_cnt = 0;
        dut_wr_cnt = 0;
        max_wait   = 0;
        for (int k = 0; k < NR; k++) wait_cnt[k] = 0;
        valid = '0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int k = 0; k < NR; k++) begin
                if (!valid[k] || acc[k] || cyc == 0) begin
                    if ($urandom_range(0, 3) != 0)
                        set_req(k, 1'b1, AW'($urandom_range(0, 31)), DW'($urandom));
                    else
                        valid[k] = 1'b0;
                end
            end
            @(negedge clk);
            acc = rr_ready & valid;
            for (int k = 0; k < NR; k++) begin
                if (valid[k] && !acc[k]) wait_cnt[k]++;
                else wait_cnt[k] = 0;
                if (wait_cnt[k] > max_wait) max_wait = wait_cnt[k];
            end
            next_cycle();
        end
        valid = '0;
        repeat (3) next_cycle();
        n_checks++;
        if (max_wait > NR - 1) begin
            n_fail++; $display("FAIL rand_starvation: got max wait %0d expected <= %0d", max_wait, NR - 1);
        end
        n_checks++;
        if (dut_wr_cnt !== exp_wr_cnt) begin
            n_fail++; $display("FAIL rand_wr_count: got %0d writes expected %0d", dut_wr_cnt, exp_wr_cnt);
        end
        rf_bad = 0;
        for (int r = 0; r < 32; r++) if (dut_rf[r] !== exp_rf[r]) rf_bad++;
        n_checks++;
        if (rf_bad != 0) begin
            n_fail++; $display("FAIL rand_regfile: got %0d differing entries expected 0", rf_bad);
        end
    endtask

    initial begin
        resetn      = 1'b0;
        valid       = '0;
        addr_bus    = '0;
        data_bus    = '0;
        fp_valid    = '0;
        fp_addr_bus = '0;
        fp_data_bus = '0;
        next_cycle();
        test_reset();
        test_single();
        test_round_robin();
        test_addr_zero();
        test_fixed_prio();
        test_idle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
